// File: rtl/inst_fetch_queue_pkg.sv
// Shared bus layout for the IF -> fetch queue -> ID path.
// The fetch queue extends the IF bus with the ADEF flag in its top bit.
package inst_fetch_queue_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int FQ_TO_DS_BUS_WD = 65;

    localparam int FQ_ADEF_BIT  = 64;
    localparam int FQ_INST_MSB  = 63;
    localparam int FQ_INST_LSB  = 32;
    localparam int FQ_PC_MSB    = 31;
    localparam int FQ_PC_LSB    = 0;

    // An instruction fetch address must be word aligned.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Decoupling FIFO between IF and ID; tags each packet with ADEF and
// discards its contents on a pipeline redirect.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fs_to_fq_valid,
    input  logic [INST_W+PC_W-1:0]    fs_to_fq_bus,
    output logic                      fq_allowin,
    input  logic                      flush,
    output logic                      fq_to_ds_valid,
    output logic [INST_W+PC_W:0]      fq_to_ds_bus,
    input  logic                      ds_allowin,
    output logic [$clog2(DEPTH):0]    fq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + INST_W + PC_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    // Allowin comes from registered state only, so ID's allowin never
    // reaches IF's allowin or the instruction SRAM enable.
    assign fq_allowin     = !reset && (count != FULL);
    assign fq_to_ds_valid = (count != '0);
    assign fq_to_ds_bus   = mem[head];
    assign fq_count       = count;

    assign push = fs_to_fq_valid && fq_allowin && !flush;
    assign pop  = fq_to_ds_valid && ds_allowin && !flush;

    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= {pc_misaligned(fs_to_fq_bus[1:0]), fs_to_fq_bus};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: single packet, fill, streaming wrap,
// flush, ADEF tagging and asynchronous reset.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_to_fq_valid;
    logic [63:0] fs_to_fq_bus;
    logic        fq_allowin;
    logic        flush;
    logic        fq_to_ds_valid;
    logic [64:0] fq_to_ds_bus;
    logic        ds_allowin;
    logic [2:0]  fq_count;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] INST = 32'h0280_0400;
    localparam logic [31:0] PC0  = 32'h1c00_0000;

    inst_fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .fs_to_fq_valid (fs_to_fq_valid),
        .fs_to_fq_bus   (fs_to_fq_bus),
        .fq_allowin     (fq_allowin),
        .flush          (flush),
        .fq_to_ds_valid (fq_to_ds_valid),
        .fq_to_ds_bus   (fq_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .fq_count       (fq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        fs_to_fq_valid = v;
        fs_to_fq_bus   = {INST, pc};
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        ds_allowin = 1'b0;
        drive(1'b0, PC0);
        step();
        chk("rst_valid", 96'(fq_to_ds_valid), 96'(0));
        chk("rst_allowin", 96'(fq_allowin), 96'(0));
        chk("rst_count", 96'(fq_count), 96'(0));
        reset = 1'b0;
        #1;
        chk("rel_allowin", 96'(fq_allowin), 96'(1));

        // single packet
        ds_allowin = 1'b1;
        drive(1'b1, PC0);
        step();
        drive(1'b0, PC0);
        chk("single_valid", 96'(fq_to_ds_valid), 96'(1));
        chk("single_bus", 96'(fq_to_ds_bus), 96'({1'b0, INST, PC0}));
        step();
        chk("single_empty_valid", 96'(fq_to_ds_valid), 96'(0));
        chk("single_empty_count", 96'(fq_count), 96'(0));
        step();
        chk("empty_pop_count", 96'(fq_count), 96'(0));

        // fill to full, then refuse a fifth packet
        ds_allowin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, PC0 + 32'(4 * i));
            step();
        end
        chk("full_count", 96'(fq_count), 96'(4));
        chk("full_allowin", 96'(fq_allowin), 96'(0));
        drive(1'b1, PC0 + 32'h10);
        step();
        chk("full_refuse", 96'(fq_count), 96'(4));
        drive(1'b0, PC0);
        ds_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 96'(fq_to_ds_bus[31:0]), 96'(PC0 + 32'(4 * i)));
            step();
        end
        chk("drain_count", 96'(fq_count), 96'(0));

        // streaming with pointer wrap
        drive(1'b1, PC0);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stream_valid", 96'(fq_to_ds_valid), 96'(1));
            chk("stream_bus", 96'(fq_to_ds_bus), 96'({1'b0, INST, PC0 + 32'(4 * i)}));
            chk("stream_count", 96'(fq_count), 96'(1));
            if (i < 9) drive(1'b1, PC0 + 32'(4 * (i + 1)));
            else       drive(1'b0, PC0);
            step();
        end
        chk("stream_end_count", 96'(fq_count), 96'(0));

        // flush with simultaneous push and pop request
        ds_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, PC0 + 32'h200 + 32'(4 * i));
            step();
        end
        chk("preflush_count", 96'(fq_count), 96'(3));
        drive(1'b1, PC0 + 32'h20c);
        ds_allowin = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        ds_allowin = 1'b0;
        drive(1'b0, PC0);
        chk("flush_count", 96'(fq_count), 96'(0));
        chk("flush_valid", 96'(fq_to_ds_valid), 96'(0));
        drive(1'b1, PC0 + 32'h100);
        step();
        drive(1'b0, PC0);
        chk("postflush_count", 96'(fq_count), 96'(1));
        chk("postflush_head", 96'(fq_to_ds_bus), 96'({1'b0, INST, PC0 + 32'h100}));
        ds_allowin = 1'b1;
        step();
        chk("postflush_empty", 96'(fq_count), 96'(0));

        // ADEF tagging
        ds_allowin = 1'b0;
        drive(1'b1, PC0 + 32'h2);
        step();
        drive(1'b1, PC0 + 32'h4);
        step();
        drive(1'b0, PC0);
        chk("adef_set", 96'(fq_to_ds_bus), 96'({1'b1, INST, PC0 + 32'h2}));
        ds_allowin = 1'b1;
        step();
        chk("adef_clr", 96'(fq_to_ds_bus), 96'({1'b0, INST, PC0 + 32'h4}));
        step();
        chk("adef_empty", 96'(fq_count), 96'(0));

        // asynchronous reset mid-operation
        ds_allowin = 1'b0;
        drive(1'b1, PC0 + 32'h300);
        step();
        drive(1'b1, PC0 + 32'h304);
        step();
        drive(1'b0, PC0);
        chk("prereset_count", 96'(fq_count), 96'(2));
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 96'(fq_to_ds_valid), 96'(0));
        chk("async_count", 96'(fq_count), 96'(0));
        chk("async_allowin", 96'(fq_allowin), 96'(0));
        #1 reset = 1'b0;
        #1;
        chk("async_rel_allowin", 96'(fq_allowin), 96'(1));
        step();
        drive(1'b1, PC0 + 32'h400);
        step();
        drive(1'b0, PC0);
        chk("resume_count", 96'(fq_count), 96'(1));
        chk("resume_bus", 96'(fq_to_ds_bus), 96'({1'b0, INST, PC0 + 32'h400}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
